// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the Riscv151 MMIO controller.
// Address offsets are decoded on addr[7:0] inside the 0x8xxx_xxxx region.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFFS_W = 8;

  localparam logic [3:0] MMIO_REGION = 4'h8;

  localparam logic [OFFS_W-1:0] MMIO_UART_CTRL    = 8'h00;
  localparam logic [OFFS_W-1:0] MMIO_UART_RX      = 8'h04;
  localparam logic [OFFS_W-1:0] MMIO_UART_TX      = 8'h08;
  localparam logic [OFFS_W-1:0] MMIO_CYCLE_CNT    = 8'h10;
  localparam logic [OFFS_W-1:0] MMIO_INST_CNT     = 8'h14;
  localparam logic [OFFS_W-1:0] MMIO_CNT_RST      = 8'h18;
  localparam logic [OFFS_W-1:0] MMIO_BR_CNT       = 8'h1C;
  localparam logic [OFFS_W-1:0] MMIO_BR_TAKEN_CNT = 8'h20;

  // Zero-extend a UART byte onto the load data bus.
  function automatic logic [DATA_W-1:0] zext_byte(input logic [BYTE_W-1:0] b);
    return {{(DATA_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/mmio_if.sv
// mmio_if: CPU memory-stage bus plus UART ready/valid streams for mmio_ctrl.
// Optional macro MMIO_BRANCH_CNT_EN adds br_valid/br_taken.
interface mmio_if #(
  parameter int unsigned ADDR_W = 32
);

  logic [ADDR_W-1:0] addr;
  logic              re;
  logic [3:0]        we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              inst_retire;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
`ifdef MMIO_BRANCH_CNT_EN
  logic              br_valid;
  logic              br_taken;
`endif

  // CPU / UART side driving the controller
  modport master (
`ifdef MMIO_BRANCH_CNT_EN
    output br_valid, br_taken,
`endif
    output addr, re, we, wdata, inst_retire, rx_data, rx_valid, tx_ready,
    input  rdata, rx_ready, tx_data, tx_valid
  );

  // Controller side
  modport slave (
`ifdef MMIO_BRANCH_CNT_EN
    input  br_valid, br_taken,
`endif
    input  addr, re, we, wdata, inst_retire, rx_data, rx_valid, tx_ready,
    output rdata, rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/mmio_rx_fifo.sv
// mmio_rx_fifo: synchronous byte FIFO for received UART data.
// Head is presented combinationally on dout_o; a separate full flag
// disambiguates equal pointers so the pointers stay log2(RX_DEPTH) bits.
module mmio_rx_fifo
  import mmio_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [BYTE_W-1:0] din_i,
  output logic [BYTE_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  logic [BYTE_W-1:0] mem_q [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q) && !full_q;
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty;

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty;

  // Pointer advance and full-flag tracking
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok) begin
      full_d = ((wr_ptr_q + PTR_W'(1)) == rd_ptr_q);
    end else if (pop_ok && !push_ok) begin
      full_d = 1'b0;
    end
  end

  // Pointer/flag state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: Riscv151 memory-mapped I/O controller.
// Holds cycle/instruction counters, bridges loads/stores to the UART
// streams and buffers received bytes in mmio_rx_fifo. Load data is
// registered to match BRAM read latency.
// Optional macro MMIO_BRANCH_CNT_EN adds branch counters at 0x1C/0x20.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic  clk,
  input  logic  rst,
  mmio_if.slave bus
);

  logic              hit;
  logic              is_load;
  logic              is_store;
  logic [OFFS_W-1:0] offset;
  logic              cnt_clr;
  logic              rx_pop;
  logic [BYTE_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              unused_ok;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [DATA_W-1:0] inst_cnt_q, inst_cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
`ifdef MMIO_BRANCH_CNT_EN
  logic [DATA_W-1:0] br_cnt_q, br_cnt_d;
  logic [DATA_W-1:0] br_taken_cnt_q, br_taken_cnt_d;
`endif

  // Address decode; a store wins when re and we collide
  assign offset   = bus.addr[OFFS_W-1:0];
  assign hit      = (bus.addr[ADDR_W-1 -: 4] == MMIO_REGION);
  assign is_store = hit && (|bus.we);
  assign is_load  = hit && bus.re && !(|bus.we);
  assign cnt_clr  = is_store && (offset == MMIO_CNT_RST);
  assign rx_pop   = is_load && (offset == MMIO_UART_RX);

  assign unused_ok = ^{bus.addr[ADDR_W-5:OFFS_W], bus.wdata[DATA_W-1:BYTE_W]};

  mmio_rx_fifo #(
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.rx_valid),
    .pop_i   (rx_pop),
    .din_i   (bus.rx_data),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign bus.rx_ready = !rx_full;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.rdata    = rdata_q;

  // Load data mux; holds when no load is requested
  always_comb begin
    rdata_d = rdata_q;
    if (bus.re) begin
      rdata_d = '0;
      if (is_load) begin
        case (offset)
          MMIO_UART_CTRL:    rdata_d = {{(DATA_W-2){1'b0}}, !rx_empty, !tx_valid_q};
          MMIO_UART_RX:      rdata_d = rx_empty ? '0 : zext_byte(rx_head);
          MMIO_CYCLE_CNT:    rdata_d = cycle_cnt_q;
          MMIO_INST_CNT:     rdata_d = inst_cnt_q;
`ifdef MMIO_BRANCH_CNT_EN
          MMIO_BR_CNT:       rdata_d = br_cnt_q;
          MMIO_BR_TAKEN_CNT: rdata_d = br_taken_cnt_q;
`endif
          default:           rdata_d = '0;
        endcase
      end
    end
  end

  // Performance counters; a clear store overrides same-cycle increments
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + DATA_W'(1);
    inst_cnt_d  = inst_cnt_q + DATA_W'(bus.inst_retire);
`ifdef MMIO_BRANCH_CNT_EN
    br_cnt_d       = br_cnt_q + DATA_W'(bus.br_valid);
    br_taken_cnt_d = br_taken_cnt_q + DATA_W'(bus.br_valid && bus.br_taken);
`endif
    if (cnt_clr) begin
      cycle_cnt_d = '0;
      inst_cnt_d  = '0;
`ifdef MMIO_BRANCH_CNT_EN
      br_cnt_d       = '0;
      br_taken_cnt_d = '0;
`endif
    end
  end

  // TX holding register: drains on handshake, loads only when free
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q) begin
      if (bus.tx_ready) tx_valid_d = 1'b0;
    end else if (is_store && (offset == MMIO_UART_TX)) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.wdata[BYTE_W-1:0];
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q     <= '0;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
`ifdef MMIO_BRANCH_CNT_EN
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
`endif
    end else begin
      rdata_q     <= rdata_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
`ifdef MMIO_BRANCH_CNT_EN
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
`endif
    end
  end

endmodule
